// File: rtl/dmem_pkg.sv
// Shared widths, FSM state type and index-width helper for the data-memory responder.
package dmem_pkg;
  localparam int LINE_W        = 256;
  localparam int ADDR_W        = 32;
  localparam int LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;

  function automatic int idx_width(input int depth_lines);
    return (depth_lines > 1) ? $clog2(depth_lines) : 1;
  endfunction
endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, asynchronous read, no reset.
// Zero-latency read, one-edge write commit, no backpressure.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = idx_width(DEPTH_LINES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency line memory for cache fill/write-back; one request in flight, ack after LATENCY cycles.
// No backpressure beyond refusing requests outside IDLE; DMEM_RESP_STATS_EN adds read/write ack counters.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int LATENCY     = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  localparam int IDX_W = idx_width(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata;
  logic              line_we;
  logic              unused_addr_bits;

  // Offset bits and bits above the index are deliberately dropped (addresses wrap).
  assign unused_addr_bits = ^{mem_addr_i[LINE_OFFSET_W-1:0],
                              mem_addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_enable_i) begin
          idx_d   = mem_addr_i[LINE_OFFSET_W +: IDX_W];
          wr_d    = mem_write_i;
          wdata_d = mem_data_i;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_ACK : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ack_o  = (state_q == ST_ACK);
    mem_data_o = (mem_ack_o && !wr_q) ? rdata : '0;
    // A reset landing on the ACK cycle must not commit the write.
    line_we    = mem_ack_o && wr_q && !rst_i;
  end

  dmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_line_array (
    .clk_i   (clk_i),
    .we_i    (line_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

`ifdef DMEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == ST_ACK) begin
      if (wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: dut0 at LATENCY=10, dut1 at LATENCY=1; expected acks queued at issue, checked by monitors.
module tb_data_memory_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en0 = 1'b0, wr0 = 1'b0, en1 = 1'b0, wr1 = 1'b0;
  logic [31:0]  addr0 = '0, addr1 = '0;
  logic [255:0] din0 = '0, din1 = '0;
  logic         ack0, ack1;
  logic [255:0] dout0, dout1;
`ifdef DMEM_RESP_STATS_EN
  logic [31:0]  rdc0, wrc0, rdc1, wrc1;
`endif

  typedef struct {
    int           cyc;
    logic [255:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_memory_responder #(.DEPTH_LINES(512), .LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en0), .mem_write_i(wr0),
    .mem_addr_i(addr0), .mem_data_i(din0), .mem_ack_o(ack0), .mem_data_o(dout0)
`ifdef DMEM_RESP_STATS_EN
    , .rd_count_o(rdc0), .wr_count_o(wrc0)
`endif
  );

  data_memory_responder #(.DEPTH_LINES(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(en1), .mem_write_i(wr1),
    .mem_addr_i(addr1), .mem_data_i(din1), .mem_ack_o(ack1), .mem_data_o(dout1)
`ifdef DMEM_RESP_STATS_EN
    , .rd_count_o(rdc1), .wr_count_o(wrc1)
`endif
  );

  // Monitors: every ack must match the head of its queue; outside ack the data bus must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (ack0 === 1'b1) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack dut0 at cyc=%0d (no request pending)", cyc);
      end else begin
        e = q0.pop_front();
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL ack_cycle dut0 got cyc=%0d exp cyc=%0d", cyc, e.cyc);
        end
        total++;
        if (dout0 !== e.data) begin
          bad++;
          $display("FAIL ack_data dut0 got %h exp %h", dout0, e.data);
        end
      end
    end else begin
      total++;
      if (ack0 !== 1'b0 || dout0 !== '0) begin
        bad++;
        $display("FAIL idle_outputs dut0 cyc=%0d ack=%b data=%h exp ack=0 data=0", cyc, ack0, dout0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack1 === 1'b1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack dut1 at cyc=%0d (no request pending)", cyc);
      end else begin
        e = q1.pop_front();
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL ack_cycle dut1 got cyc=%0d exp cyc=%0d", cyc, e.cyc);
        end
        total++;
        if (dout1 !== e.data) begin
          bad++;
          $display("FAIL ack_data dut1 got %h exp %h", dout1, e.data);
        end
      end
    end else begin
      total++;
      if (ack1 !== 1'b0 || dout1 !== '0) begin
        bad++;
        $display("FAIL idle_outputs dut1 cyc=%0d ack=%b data=%h exp ack=0 data=0", cyc, ack1, dout1);
      end
    end
  end

  task automatic wait_empty(input bit sel, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if ((sel ? q1.size() : q0.size()) == 0) break;
      @(negedge clk);
      #1;
    end
    total++;
    if ((sel ? q1.size() : q0.size()) != 0) begin
      bad++;
      $display("FAIL %s timeout: %0d acks outstanding, exp 0", name,
               sel ? q1.size() : q0.size());
      if (sel) q1.delete(); else q0.delete();
    end
  endtask

  // Issue one request, queue its expected ack (cycle and data), then wait for the monitor to consume it.
  task automatic do_req(input bit sel, input bit w, input logic [31:0] a,
                        input logic [255:0] d, input logic [255:0] exp_d, input string name);
    exp_t e;
    @(negedge clk);
    if (sel) begin en1 = 1'b1; wr1 = w; addr1 = a; din1 = d; end
    else     begin en0 = 1'b1; wr0 = w; addr0 = a; din0 = d; end
    e.cyc  = cyc + (sel ? 1 : 10);
    e.data = w ? 256'd0 : exp_d;
    if (sel) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    #1;
    if (sel) en1 = 1'b0; else en0 = 1'b0;
    wait_empty(sel, 20, name);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] beef, wrapd, l3old, one, d1;
    exp_t         e;
    int           c;
    beef  = {8{32'hDEAD_BEEF}};
    wrapd = {8{32'hA5A5_0F0F}};
    l3old = {8{32'h3333_3333}};
    one   = 256'h1;
    d1    = {4{64'h0123_4567_89AB_CDEF}};

    // Reset for two edges, then idle for 20 cycles with enable low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (ack0 !== 1'b0 || dout0 !== '0) begin
      bad++;
      $display("FAIL reset_state dut0 ack=%b data=%h exp 0/0", ack0, dout0);
    end
    repeat (20) @(negedge clk);

    // Write then read with ignored offset bits.
    do_req(1'b0, 1'b1, 32'h0000_0040, beef, '0, "write_0x40");
    do_req(1'b0, 1'b0, 32'h0000_005C, '0, beef, "read_0x5C");

    // Upper bits wrap: 0x4000 lands on line 0.
    do_req(1'b0, 1'b1, 32'h0000_4000, wrapd, '0, "write_wrap");
    do_req(1'b0, 1'b0, 32'h0000_0000, '0, wrapd, "read_wrap");

    // Enable held high: three reads spaced LATENCY+1 apart.
    @(negedge clk);
    en0 = 1'b1; wr0 = 1'b0; addr0 = 32'h0000_0040;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc  = c + 10 + 11 * k;
      e.data = beef;
      q0.push_back(e);
    end
    wait_empty(1'b0, 50, "held_enable");
    en0 = 1'b0;
    repeat (15) @(negedge clk);

    // Reset mid-operation drops the pending write to line 3.
    do_req(1'b0, 1'b1, 32'h0000_0060, l3old, '0, "write_line3");
    @(negedge clk);
    en0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0060; din0 = one;
    @(negedge clk);
    en0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    do_req(1'b0, 1'b0, 32'h0000_0060, '0, l3old, "read_line3_after_reset");

    // LATENCY=1 instance: ack the very next cycle.
    do_req(1'b1, 1'b1, 32'h0000_0020, d1, '0, "lat1_write");
    do_req(1'b1, 1'b0, 32'h0000_0020, '0, d1, "lat1_read");
`ifdef DMEM_RESP_STATS_EN
    total++;
    if (rdc1 !== 32'd1 || wrc1 !== 32'd1) begin
      bad++;
      $display("FAIL lat1_stats rd=%0d wr=%0d exp rd=1 wr=1", rdc1, wrc1);
    end
    total++;
    if (rdc0 !== 32'd1 || wrc0 !== 32'd0) begin
      bad++;
      $display("FAIL dut0_stats_after_reset rd=%0d wr=%0d exp rd=1 wr=0", rdc0, wrc0);
    end
`endif

    repeat (5) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected q0=%0d q1=%0d exp 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end
endmodule
